// File: rtl/fifo_ptr_pkg.sv
// Shared FIFO pointer helpers: Gray/binary conversion and default sizing.
// Functions work on a fixed maximum width; callers zero-extend narrower pointers.
package fifo_ptr_pkg;

  localparam int FIFO_ADDR_WIDTH = 4;
  localparam int FIFO_AE_THRESH  = 2;

  // Widest pointer supported: 12 address bits plus the wrap bit.
  localparam int PTR_MAX_W = 13;

  typedef logic [PTR_MAX_W-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero upper bits leave the prefix XOR unchanged, so narrower pointers convert correctly.
  function automatic ptr_t gray2bin(input ptr_t gray);
    ptr_t bin;
    bin = gray;
    for (int i = 1; i < PTR_MAX_W; i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/rd_ptr_ctrl_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing clock domains.
// Shared by the read-side and write-side pointer blocks.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rd_ptr_ctrl.sv
// Read-side FIFO pointer controller: read pointer, empty/underflow flags, synchronized write pointer.
// Optional macro RD_PTR_LEVEL_EN adds the occupancy count and a threshold-based almost-empty flag.
module rd_ptr_ctrl
  import fifo_ptr_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int AE_THRESH  = FIFO_AE_THRESH
) (
  input  logic                  rd_clk_gen,
  input  logic                  rst_rd_gen_in,
  input  logic                  rd_en_gen,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray_in,
  output logic [ADDR_WIDTH-1:0] rd_addr_gen,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray_out,
  output logic                  rd_empty,
  output logic                  rd_almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  rd_underflow
);

  localparam int PW = ADDR_WIDTH + 1;

  if (ADDR_WIDTH < 2 || ADDR_WIDTH > 12) begin : g_bad_addr_width
    $error("rd_ptr_ctrl: ADDR_WIDTH must be in 2..12");
  end
  if (AE_THRESH < 0 || AE_THRESH > (1 << ADDR_WIDTH)) begin : g_bad_ae_thresh
    $error("rd_ptr_ctrl: AE_THRESH must be in 0..2**ADDR_WIDTH");
  end

  logic [PW-1:0] rd_bin;
  logic [PW-1:0] rd_bin_next;
  logic [PW-1:0] rd_gray_next;
  logic [PW-1:0] wq2_gray;
  logic          rd_accept;

  sync_2ff #(
    .WIDTH(PW)
  ) u_wr_sync (
    .clk  (rd_clk_gen),
    .reset(rst_rd_gen_in),
    .d    (wr_ptr_gray_in),
    .q    (wq2_gray)
  );

  // Flags are computed from the post-read pointer so they reflect this cycle's read.
  always_comb begin
    rd_accept    = rd_en_gen && !rd_empty;
    rd_bin_next  = rd_bin + PW'(rd_accept);
    rd_gray_next = PW'(bin2gray(ptr_t'(rd_bin_next)));
  end

  always_ff @(posedge rd_clk_gen) begin
    if (rst_rd_gen_in) begin
      rd_bin          <= '0;
      rd_ptr_gray_out <= '0;
      rd_empty        <= 1'b1;
      rd_underflow    <= 1'b0;
    end else begin
      rd_bin          <= rd_bin_next;
      rd_ptr_gray_out <= rd_gray_next;
      rd_empty        <= (rd_gray_next == wq2_gray);
      if (rd_en_gen && rd_empty) begin
        rd_underflow <= 1'b1;
      end
    end
  end

  assign rd_addr_gen = rd_bin[ADDR_WIDTH-1:0];

`ifdef RD_PTR_LEVEL_EN
  logic [PW-1:0] level_next;

  // Pointer difference modulo 2**PW cannot exceed the depth while the writer respects full.
  always_comb begin
    level_next = PW'(gray2bin(ptr_t'(wq2_gray))) - rd_bin_next;
  end

  always_ff @(posedge rd_clk_gen) begin
    if (rst_rd_gen_in) begin
      rd_level        <= '0;
      rd_almost_empty <= 1'b1;
    end else begin
      rd_level        <= level_next;
      rd_almost_empty <= (32'(level_next) <= AE_THRESH);
    end
  end
`else
  assign rd_level        = '0;
  assign rd_almost_empty = rd_empty;
`endif

endmodule
